serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial two's-complement subtractor: computes diff = a - b one bit per
//   clock, LSB first, over WIDTH cycles. Inverse operation to the ripple-carry
//   adder in the ALU datapath. Used where area matters more than latency.
//   Reports unsigned borrow and signed overflow, mirroring the adder's flag.
// PARAMETERS
//   WIDTH  16  operand/result width in bits (>= 2)
// PORTS
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   start     in   1      request; sampled only when not busy
//   a         in   WIDTH  minuend, captured on accepted start
//   b         in   WIDTH  subtrahend, captured on accepted start
//   busy      out  1      operation in progress
//   done      out  1      one-cycle pulse: diff/borrow/overflow valid
//   diff      out  WIDTH  a - b (mod 2^WIDTH), held until next accepted start
//   borrow    out  1      1 iff unsigned a < b
//   overflow  out  1      signed overflow of a - b
// BEHAVIOUR
//   Reset (rst_n low, any time, async): state=IDLE; busy=0, done=0, diff=0,
//     borrow=0, overflow=0; operand regs, bit counter, borrow bit cleared.
//     Reset mid-operation aborts it; no done pulse follows.
//   States: IDLE -> SHIFT -> FINISH -> IDLE.
//   IDLE: start=1 at edge N -> latch a,b; counter=0; borrow bit=0; go SHIFT;
//     busy=1 from edge N.
//   SHIFT: per edge, bit i = counter:
//     d_i = a_i ^ b_i ^ br;  br' = (~a_i & b_i) | (~a_i & br) | (b_i & br)
//     d_i shifted into result reg from MSB side (result right-shift);
//     operand regs right-shift; counter+1. After WIDTH edges (counter wraps
//     from WIDTH-1) go FINISH.
//   FINISH (single cycle, entered at edge N+WIDTH): busy=0, done=1;
//     diff=result reg; borrow=final br;
//     overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]) using latched
//     original operand MSBs (kept in dedicated regs, not shifted copies).
//   Next edge: FINISH -> IDLE, done=0. diff/borrow/overflow hold.
//   Latency: start at edge N -> done high in cycle after edge N+WIDTH.
//   start while busy (SHIFT): ignored, no queueing; a/b changes ignored.
//   start=1 during FINISH cycle: accepted (FINISH acts as IDLE for start);
//     go SHIFT, done still pulses that cycle, outputs still update that cycle.
//   start held high continuously: back-to-back ops, one every WIDTH+1 cycles.
//   diff/borrow/overflow change only on the FINISH-entry edge (or reset).
// TESTING
//   a=0x0005,b=0x0003 -> done after 16 cycles; diff=0x0002,borrow=0,ovf=0
//   a=0x0003,b=0x0005 -> diff=0xFFFE, borrow=1, overflow=0
//   a=0x8000,b=0x0001 -> diff=0x7FFF, borrow=0, overflow=1
//   a=0x7FFF,b=0xFFFF -> diff=0x8000, borrow=1, overflow=1
//   start 0x1234-0x1234, pulse start w/ a=0xFFFF at cycle 5 -> ignored;
//     diff=0x0000,borrow=0,ovf=0; exactly one done pulse
//   rst_n low at cycle 8 of an op -> all outputs 0 immediately, no done;
//     start held high after release -> done every 17 cycles, correct results

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first.
// Reports unsigned borrow and signed overflow on a one-cycle done pulse.
module serial_subtractor #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_br;
    logic [CW-1:0]    r_cnt;

    logic             w_ai;
    logic             w_bi;
    logic             w_d;
    logic             w_br_nxt;
    logic             w_last;
    logic [WIDTH-1:0] w_res_nxt;

    always_comb begin
        w_ai      = r_a[0];
        w_bi      = r_b[0];
        w_d       = w_ai ^ w_bi ^ r_br;
        w_br_nxt  = (~w_ai & w_bi) | (~w_ai & r_br) | (w_bi & r_br);
        w_last    = (r_cnt == CW'(WIDTH - 1));
        w_res_nxt = {w_d, r_res[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            diff     <= '0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (r_state)
                // FINISH accepts a new start exactly like IDLE, giving WIDTH+1 cycle throughput
                IDLE, FINISH: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
                        r_res   <= '0;
                        r_br    <= 1'b0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= SHIFT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SHIFT: begin
                    r_res <= w_res_nxt;
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_br_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        diff     <= w_res_nxt;
                        borrow   <= w_br_nxt;
                        overflow <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
                        r_state  <= FINISH;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: vector table plus random ops checked through an
// expected-result queue, and hand sequences for ignore, abort and back-to-back cases.
module tb_serial_subtractor;

    localparam int unsigned W = 16;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         br;
        logic         ov;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         overflow;

    int   checks;
    int   errors;
    int   done_cnt;
    vec_t sb[$];
    vec_t tbl[8];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow(borrow), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic [W-1:0] ma, input logic [W-1:0] mb);
        vec_t v;
        v.a  = ma;
        v.b  = mb;
        v.d  = ma - mb;
        v.br = (ma < mb);
        v.ov = (ma[W-1] != mb[W-1]) && (v.d[W-1] != ma[W-1]);
        return v;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                vec_t e;
                e = sb.pop_front();
                check("diff", 32'(diff), 32'(e.d));
                check("borrow", 32'(borrow), 32'(e.br));
                check("overflow", 32'(overflow), 32'(e.ov));
            end
        end
    end

    // Start one op at a negedge, wait for done, check latency and post-op hold
    task automatic run_op(input vec_t e);
        int n;
        logic [W-1:0] held;
        start = 1'b1;
        a     = e.a;
        b     = e.b;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        n = 1;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(W + 1));
        check("busy_at_done", 32'(busy), 32'd0);
        held = diff;
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("diff_hold", 32'(diff), 32'(held));
    endtask

    initial begin
        int n;
        int d0;
        checks   = 0;
        errors   = 0;
        done_cnt = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;

        tbl[0] = '{16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0};
        tbl[1] = '{16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0};
        tbl[2] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1};
        tbl[3] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1};
        tbl[4] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[5] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0};
        tbl[6] = '{16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b0};
        tbl[7] = '{16'h0000, 16'h8000, 16'h8000, 1'b1, 1'b1};

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_flags", {30'd0, borrow, overflow}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_op(tbl[i]);
        for (int i = 0; i < 10; i++) run_op(model(W'($urandom), W'($urandom)));

        // start pulse while busy must be ignored
        d0    = done_cnt;
        start = 1'b1;
        a     = 16'h1234;
        b     = 16'h1234;
        sb.push_back(model(16'h1234, 16'h1234));
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        a     = 16'hFFFF;
        b     = 16'h0000;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        check("ignore_one_done", 32'(done_cnt - d0), 32'd1);
        check("ignore_diff", 32'(diff), 32'h0000);

        // reset mid-operation: outputs clear immediately and no done follows
        run_op(tbl[3]);
        start = 1'b1;
        a     = 16'h0003;
        b     = 16'h0005;
        sb.push_back(model(16'h0003, 16'h0005));
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_flags", {30'd0, borrow, overflow}, 32'd0);
        d0 = done_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);

        // start held high: back-to-back ops every W+1 cycles
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a = tbl[k + 1].a;
            b = tbl[k + 1].b;
            sb.push_back(tbl[k + 1]);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!done && n < 40);
            check("b2b_period", 32'(n), 32'(W + 1));
        end
        start = 1'b0;
        repeat (25) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
